// File: rtl/adf4030_trig_pkg.sv
// adf4030_trig_pkg: shared state/mode encodings and widths for the trigger scheduler
package adf4030_trig_pkg;
  localparam int STATE_W = 3;
  localparam int MODE_W  = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_WAIT = 3'd2,
    ST_FIRE = 3'd3,
    ST_DONE = 3'd4
  } state_e;
  typedef enum logic [MODE_W-1:0] {
    MD_SINGLE     = 2'd0,
    MD_BURST      = 2'd1,
    MD_CONT       = 2'd2,
    MD_SINGLE_ALT = 2'd3
  } mode_e;
endpackage

// File: rtl/adf4030_trig_channel.sv
// adf4030_trig_channel: one trigger channel -- FSM, shadow config and burst counter
// Ports: clk/rstn; bsync, arm, abort strobes; en; cnt (shared period counter);
// ratio (period length); phase/mode/burst_len (live config, captured on arm);
// trig (one-cycle pulse), state (FSM encoding), err (sticky phase error).
module adf4030_trig_channel
  import adf4030_trig_pkg::*;
#(
  parameter int PHASE_WIDTH = 16,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   bsync,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] cnt,
  input  logic [PHASE_WIDTH-1:0] ratio,
  input  logic [PHASE_WIDTH-1:0] phase,
  input  logic [MODE_W-1:0]      mode,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   trig,
  output logic [STATE_W-1:0]     state,
  output logic                   err
);
  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic                   err_q, err_d;
  logic                   arm_ok;
  // arm is only honoured from a resting state
  assign arm_ok = arm && (state_q == ST_IDLE || state_q == ST_DONE);
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    err_d   = err_q;
    if (abort || !en) state_d = ST_IDLE;
    else if (arm_ok) begin
      state_d = ST_SYNC;
      mode_d  = mode_e'(mode);
      phase_d = phase;
      rem_d   = burst_len == '0 ? BURST_WIDTH'(1) : burst_len;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: state_d = bsync ? ST_WAIT : ST_SYNC;
        ST_WAIT: begin
          // an unreachable phase is fatal; a missed period is only flagged
          if (phase_q >= ratio) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (cnt == phase_q) state_d = ST_FIRE;
          else if (bsync) err_d = 1'b1;
        end
        ST_FIRE: begin
          rem_d   = mode_q == MD_BURST ? rem_q - BURST_WIDTH'(1) : rem_q;
          state_d = (mode_q == MD_CONT || (mode_q == MD_BURST && rem_q != BURST_WIDTH'(1)))
                    ? ST_SYNC : ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      mode_q  <= MD_SINGLE;
      phase_q <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end
  // abort/disable must kill a pulse already in its FIRE cycle
  assign trig  = state_q == ST_FIRE && !abort && en;
  assign state = state_q;
  assign err   = err_q;
endmodule

// File: rtl/adf4030_trig_scheduler.sv
// adf4030_trig_scheduler: BSYNC-aligned multi-channel trigger scheduler
// Ports: clk/rstn; bsync strobe and bsync_ratio period; arm/abort strobes;
// per-channel ch_en, ch_phase, ch_mode, ch_burst_len (flattened vectors);
// outputs trig_out pulses, ch_state encodings, sticky phase_error, busy.
module adf4030_trig_scheduler
  import adf4030_trig_pkg::*;
#(
  parameter int CHANNEL_COUNT = 8,
  parameter int PHASE_WIDTH   = 16,
  parameter int BURST_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               bsync,
  input  logic [PHASE_WIDTH-1:0]             bsync_ratio,
  input  logic                               arm,
  input  logic                               abort,
  input  logic [CHANNEL_COUNT-1:0]           ch_en,
  input  logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] ch_phase,
  input  logic [CHANNEL_COUNT*MODE_W-1:0]    ch_mode,
  input  logic [CHANNEL_COUNT*BURST_WIDTH-1:0] ch_burst_len,
  output logic [CHANNEL_COUNT-1:0]           trig_out,
  output logic [CHANNEL_COUNT*STATE_W-1:0]   ch_state,
  output logic [CHANNEL_COUNT-1:0]           phase_error,
  output logic                               busy
);
  logic [PHASE_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CHANNEL_COUNT-1:0] act;
  // saturating period counter, restarted by bsync
  assign cnt_d = bsync ? '0 : cnt_q + PHASE_WIDTH'(cnt_q != '1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_ch
    adf4030_trig_channel #(
      .PHASE_WIDTH(PHASE_WIDTH),
      .BURST_WIDTH(BURST_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .bsync    (bsync),
      .arm      (arm),
      .abort    (abort),
      .en       (ch_en[g]),
      .cnt      (cnt_q),
      .ratio    (bsync_ratio),
      .phase    (ch_phase[g*PHASE_WIDTH +: PHASE_WIDTH]),
      .mode     (ch_mode[g*MODE_W +: MODE_W]),
      .burst_len(ch_burst_len[g*BURST_WIDTH +: BURST_WIDTH]),
      .trig     (trig_out[g]),
      .state    (ch_state[g*STATE_W +: STATE_W]),
      .err      (phase_error[g])
    );
    assign act[g] = ch_state[g*STATE_W +: STATE_W] != ST_IDLE &&
                    ch_state[g*STATE_W +: STATE_W] != ST_DONE;
  end
  assign busy = |act;
endmodule
